serial_mod_reducer: RTL and testbench

Parametrised serial modulo reducer: accepts an N_CHUNKS × W-bit operand one chunk per accepted beat, most significant chunk first, and produces operand mod MOD. It generalises the fixed 6-bit/8-chunk/mod-7 reducer to arbitrary chunk width, chunk count and modulus. It adds a per-chunk valid qualifier, a one-cycle done pulse and an optional abort. The block sits between a chunk-serialising producer and consumers such as checksum/divisibility logic, and is built as controller + datapath under one top.

---
 rtl/serial_mod_reducer_if.sv | 33 +++
 rtl/serial_mod_reducer.sv | 100 ++++++++++
 tb/tb_serial_mod_reducer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mod_reducer_if.sv
// Chunk-serial operand/result bundle for serial_mod_reducer.
// The abort signal exists only when SSR_ABORT_EN is defined.
interface serial_mod_reducer_if #(
    parameter int W  = 6,
    parameter int RW = 3
);
    logic          start;
    logic [W-1:0]  in_bus;
    logic          in_valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic [RW-1:0] out_bus;
`ifdef SSR_ABORT_EN
    logic          abort;
`endif

    modport master (
        output start, in_bus, in_valid,
`ifdef SSR_ABORT_EN
        output abort,
`endif
        input  ready, busy, done, out_bus
    );

    modport slave (
        input  start, in_bus, in_valid,
`ifdef SSR_ABORT_EN
        input  abort,
`endif
        output ready, busy, done, out_bus
    );
endinterface

// File: rtl/serial_mod_reducer.sv
// Serial modulo reducer: folds N_CHUNKS W-bit chunks (MSB chunk first) into operand mod MOD.
// Optional cancel input enabled by defining SSR_ABORT_EN.
module serial_mod_reducer #(
    parameter int W        = 6,
    parameter int N_CHUNKS = 8,
    parameter int MOD      = 7
) (
    input  logic                clk,
    input  logic                rst,
    serial_mod_reducer_if.slave bus
);
    localparam int RW = $clog2(MOD);
    localparam int CW = $clog2(N_CHUNKS + 1);
    localparam logic [RW+W-1:0] MOD_W    = (RW+W)'(MOD);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N_CHUNKS - 1);

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, ACC, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   rem;
    logic [CW-1:0]   cnt;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic [RW+W-1:0] acc_wide;
    logic [RW-1:0]   rem_next;

    // rem < MOD always, so {rem, chunk} fits in RW+W bits without overflow
    always_comb begin
        acc_wide = {rem, bus.in_bus};
        rem_next = RW'(acc_wide % MOD_W);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rem     <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end
`ifdef SSR_ABORT_EN
        else if (bus.abort && (state == WAIT || state == LOAD || state == ACC)) begin
            state   <= IDLE;
            rem     <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= WAIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!bus.start) state <= LOAD;
                end
                LOAD: begin
                    rem   <= '0;
                    cnt   <= '0;
                    state <= ACC;
                end
                ACC: begin
                    if (bus.in_valid) begin
                        rem <= rem_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out_bus = rem;
endmodule

// File: tb/tb_serial_mod_reducer.sv
// Directed bench for serial_mod_reducer: default 6x8 mod 7 instance plus an 8x4 mod 10 instance.
module tb_serial_mod_reducer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_mod_reducer_if #(.W(6), .RW(3)) a_if ();
    serial_mod_reducer_if #(.W(8), .RW(4)) b_if ();

    serial_mod_reducer #(.W(6), .N_CHUNKS(8), .MOD(7)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    serial_mod_reducer #(.W(8), .N_CHUNKS(4), .MOD(10)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        logic [47:0] op;
        bit          bub;
        int          hold;
        logic [2:0]  exp;
    } vec_a_t;

    typedef struct {
        logic [31:0] op;
        logic [3:0]  exp;
    } vec_b_t;

    vec_a_t va[8];
    vec_b_t vb[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge while IDLE; start is sampled high for hold edges.
    task automatic begin_a(input int hold);
        check("a_ready_before_start", a_if.ready, 1);
        a_if.start = 1'b1;
        repeat (hold) @(negedge clk);
    endtask

    // Called at a negedge in WAIT: releases start, feeds chunks at t+2, checks done at the exact cycle.
    task automatic feed_a(input logic [47:0] op, input bit bub, input logic [2:0] exp,
                          input bit keep, input bit ab_done);
        bit early = 1'b0;
        a_if.start    = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_bus   = 6'h3F;
        @(negedge clk);
        check("a_busy_load", a_if.busy, 1);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_bus   = op[47-6*k -: 6];
            if (a_if.done) early = 1'b1;
            @(negedge clk);
            if (bub && k < 7) begin
                a_if.in_valid = 1'b0;
                a_if.in_bus   = 6'h3F;
                if (a_if.done) early = 1'b1;
                @(negedge clk);
            end
        end
        check("a_no_early_done", early, 0);
        a_if.in_valid = 1'b1;
        a_if.in_bus   = 6'h3F;
        if (keep) a_if.start = 1'b1;
`ifdef SSR_ABORT_EN
        a_if.abort = ab_done;
`endif
        check("a_done_pulse", a_if.done, 1);
        check("a_result", a_if.out_bus, exp);
        @(negedge clk);
        check("a_ready_after", a_if.ready, 1);
        check("a_done_cleared", a_if.done, 0);
        check("a_result_held", a_if.out_bus, exp);
        a_if.in_valid = 1'b0;
`ifdef SSR_ABORT_EN
        a_if.abort = 1'b0;
`endif
        if (ab_done) check("a_abort_done_ignored", a_if.busy, 0);
    endtask

    task automatic run_b(input logic [31:0] op, input logic [3:0] exp);
        bit early = 1'b0;
        check("b_ready_before_start", b_if.ready, 1);
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            b_if.in_valid = 1'b1;
            b_if.in_bus   = op[31-8*k -: 8];
            if (b_if.done) early = 1'b1;
            @(negedge clk);
        end
        b_if.in_valid = 1'b0;
        check("b_no_early_done", early, 0);
        check("b_done_pulse", b_if.done, 1);
        check("b_result", b_if.out_bus, exp);
        @(negedge clk);
        check("b_ready_after", b_if.ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        va[0] = '{48'hFFFF_FFFF_FFFF, 1'b0, 1, 3'd0};
        va[1] = '{48'h0400_0000_0000, 1'b0, 1, 3'd1};
        va[2] = '{48'h0000_0000_000A, 1'b0, 1, 3'd3};
        va[3] = '{48'h0400_0000_0000, 1'b1, 5, 3'd1};
        va[4] = '{48'h0000_0000_000A, 1'b1, 1, 3'd3};
        va[5] = '{48'h8000_0000_0000, 1'b0, 2, 3'd4};
        va[6] = '{48'h0000_0000_0040, 1'b0, 1, 3'd1};
        va[7] = '{48'hFFFF_FFFF_FFFF, 1'b1, 3, 3'd0};
        vb[0] = '{32'h0000_012C, 4'd0};
        vb[1] = '{32'hFFFF_FFFF, 4'd5};
        vb[2] = '{32'h0000_0001, 4'd1};
        vb[3] = '{32'h1234_5678, 4'd6};
        vb[4] = '{32'h0000_0100, 4'd6};

        a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.in_bus = '0;
        b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.in_bus = '0;
`ifdef SSR_ABORT_EN
        a_if.abort = 1'b0;
        b_if.abort = 1'b0;
`endif
        rst = 1'b0;
        a_if.start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", a_if.ready, 1);
        check("rst_busy", a_if.busy, 0);
        check("rst_done", a_if.done, 0);
        check("rst_out", a_if.out_bus, 0);
        check("rst_b_out", b_if.out_bus, 0);
        a_if.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            begin_a(va[i].hold);
            feed_a(va[i].op, va[i].bub, va[i].exp, 1'b0, 1'b0);
        end

        // Back-to-back: start held through DONE re-enters WAIT straight from IDLE
        begin_a(1);
        feed_a(48'h0000_0000_000A, 1'b0, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("a_chain_busy", a_if.busy, 1);
        feed_a(48'h8000_0000_0000, 1'b0, 3'd4, 1'b0, 1'b0);

        // Reset mid-accumulation after four chunks of 6'h01
        begin_a(1);
        a_if.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_bus   = 6'h01;
            @(negedge clk);
        end
        check("a_partial_rem", a_if.out_bus, 4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        a_if.in_valid = 1'b0;
        check("a_midrst_ready", a_if.ready, 1);
        check("a_midrst_busy", a_if.busy, 0);
        check("a_midrst_out", a_if.out_bus, 0);
        check("a_midrst_done", a_if.done, 0);
        @(negedge clk);
        check("a_midrst_no_done", a_if.done, 0);
        begin_a(1);
        feed_a(48'h0400_0000_0000, 1'b0, 3'd1, 1'b0, 1'b0);

`ifdef SSR_ABORT_EN
        begin_a(1);
        a_if.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            a_if.in_valid = 1'b1;
            a_if.in_bus   = 6'h01;
            @(negedge clk);
        end
        check("a_pre_abort_rem", a_if.out_bus, 3);
        a_if.abort = 1'b1;
        @(negedge clk);
        a_if.abort    = 1'b0;
        a_if.in_valid = 1'b0;
        check("a_abort_ready", a_if.ready, 1);
        check("a_abort_busy", a_if.busy, 0);
        check("a_abort_out", a_if.out_bus, 0);
        check("a_abort_done", a_if.done, 0);
        @(negedge clk);
        check("a_abort_no_done", a_if.done, 0);
        begin_a(1);
        feed_a(48'h0000_0000_000A, 1'b0, 3'd3, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 5; i++) begin
            run_b(vb[i].op, vb[i].exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
